array_rw_sched: RTL and testbench

- Scheduler and init sequencer in front of one 512x11 1R1W SRAM macro (registered read address, 1-cycle read latency).
- After reset it clears every entry to a constant, then shares the single read port between two read requesters.
- It also forwards one write requester to the write port.
- Sits between a predictor-style table's lookup/update logic and the array macro.

---
 rtl/array_rw_sched.sv | 127 ++++++++++++
 tb/tb_array_rw_sched.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/array_rw_sched.sv
// Init sequencer and read/write scheduler in front of a 1R1W SRAM macro.
// Optional round-robin read arbitration: define ARRAY_RW_SCHED_RR_ARB_EN.
module array_rw_sched #(
  parameter int                DEPTH    = 512,
  parameter int                ADDR_W   = 9,
  parameter int                DATA_W   = 11,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  output logic              init_done,
  output logic              dbg_state,
  input  logic              rd0_valid,
  output logic              rd0_ready,
  input  logic [ADDR_W-1:0] rd0_addr,
  input  logic              rd1_valid,
  output logic              rd1_ready,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic              resp_valid,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              sram_r_en,
  output logic [ADDR_W-1:0] sram_r_addr,
  input  logic [DATA_W-1:0] sram_r_data,
  output logic              sram_w_en,
  output logic [ADDR_W-1:0] sram_w_addr,
  output logic [DATA_W-1:0] sram_w_data
);

  // Handshake: a read is granted in the cycle rdN_valid && rdN_ready are both
  // high; its data appears with resp_valid exactly one cycle later. A write is
  // accepted in the cycle wr_valid && wr_ready; no backpressure exists in RUN.

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              init_done_q;
  logic              resp_valid_q, resp_id_q;
  logic              gnt0, gnt1;

`ifdef ARRAY_RW_SCHED_RR_ARB_EN
  logic ptr_q, ptr_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd0_ready   = 1'b0;
    rd1_ready   = 1'b0;
    wr_ready    = 1'b0;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    sram_r_en   = 1'b0;
    sram_r_addr = rd0_addr;
    sram_w_en   = 1'b0;
    sram_w_addr = wr_addr;
    sram_w_data = wr_data;
`ifdef ARRAY_RW_SCHED_RR_ARB_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_INIT: begin
        sram_w_en   = 1'b1;
        sram_w_addr = cnt_q;
        sram_w_data = INIT_VAL;
        cnt_d       = cnt_q + 1'b1;
        if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        wr_ready  = 1'b1;
        sram_w_en = wr_valid;
`ifdef ARRAY_RW_SCHED_RR_ARB_EN
        rd0_ready = !ptr_q || !rd1_valid;
        rd1_ready = ptr_q || !rd0_valid;
        gnt0      = rd0_valid && rd0_ready;
        gnt1      = rd1_valid && rd1_ready;
        // The pointer always moves to the requester that was not served.
        if (gnt0)      ptr_d = 1'b1;
        else if (gnt1) ptr_d = 1'b0;
`else
        rd0_ready = 1'b1;
        rd1_ready = !rd0_valid;
        gnt0      = rd0_valid;
        gnt1      = rd1_valid && !rd0_valid;
`endif
        sram_r_en   = gnt0 || gnt1;
        sram_r_addr = gnt1 ? rd1_addr : rd0_addr;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      init_done_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_done_q  <= (state_d == ST_RUN);
      resp_valid_q <= gnt0 || gnt1;
      if (gnt0 || gnt1) resp_id_q <= gnt1;
    end
  end

`ifdef ARRAY_RW_SCHED_RR_ARB_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
`endif

  assign init_done  = init_done_q;
  assign dbg_state  = state_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = sram_r_data;

endmodule

// File: tb/tb_array_rw_sched.sv
// Bench for array_rw_sched: SRAM model, behavioural scoreboard, random traffic.
module tb_array_rw_sched;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        init_done, dbg_state;
  logic        rd0_valid = 1'b0, rd0_ready;
  logic [8:0]  rd0_addr = '0;
  logic        rd1_valid = 1'b0, rd1_ready;
  logic [8:0]  rd1_addr = '0;
  logic        resp_valid, resp_id;
  logic [10:0] resp_data;
  logic        wr_valid = 1'b0, wr_ready;
  logic [8:0]  wr_addr = '0;
  logic [10:0] wr_data = '0;
  logic        sram_r_en, sram_w_en;
  logic [8:0]  sram_r_addr, sram_w_addr;
  logic [10:0] sram_r_data, sram_w_data;

  int checks = 0;
  int failures = 0;

`ifdef ARRAY_RW_SCHED_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  array_rw_sched dut (
    .clock(clock), .reset_n(reset_n), .init_done(init_done), .dbg_state(dbg_state),
    .rd0_valid(rd0_valid), .rd0_ready(rd0_ready), .rd0_addr(rd0_addr),
    .rd1_valid(rd1_valid), .rd1_ready(rd1_ready), .rd1_addr(rd1_addr),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .sram_r_en(sram_r_en), .sram_r_addr(sram_r_addr), .sram_r_data(sram_r_data),
    .sram_w_en(sram_w_en), .sram_w_addr(sram_w_addr), .sram_w_data(sram_w_data)
  );

  always #5 clock = ~clock;

  // Write-first SRAM macro with registered read
  logic [10:0] sram [512];
  always @(posedge clock) begin
    if (sram_r_en)
      sram_r_data <= (sram_w_en && sram_w_addr == sram_r_addr) ? sram_w_data : sram[sram_r_addr];
    if (sram_w_en) sram[sram_w_addr] <= sram_w_data;
  end

  // Reference: table contents, preferred requester, expected responses {id,data}
  logic [10:0] exp_mem [512];
  logic        pref = 1'b0;
  logic [11:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    rd0_valid = 1'b0; rd1_valid = 1'b0; wr_valid = 1'b0;
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_w_addr", sram_w_addr, 0);
    exp_q.delete();
    pref = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Walks n INIT cycles; n==512 also checks the rise of init_done afterwards.
  task automatic init_sweep(input int n);
    int bad_we = 0, bad_addr = 0, bad_data = 0, bad_rdy = 0, bad_done = 0;
    for (int k = 0; k < n; k++) begin
      rd0_valid = 1'($urandom); rd1_valid = 1'($urandom); wr_valid = 1'($urandom);
      rd0_addr = 9'($urandom); rd1_addr = 9'($urandom); wr_addr = 9'($urandom);
      @(negedge clock);
      if (sram_w_en !== 1'b1) bad_we++;
      if (sram_w_addr !== 9'(k)) bad_addr++;
      if (sram_w_data !== 11'h000) bad_data++;
      if (rd0_ready || rd1_ready || wr_ready || sram_r_en || resp_valid) bad_rdy++;
      if (init_done !== 1'b0) bad_done++;
      @(posedge clock); #1;
    end
    chk("init_w_en", bad_we, 0);
    chk("init_addr_seq", bad_addr, 0);
    chk("init_data", bad_data, 0);
    chk("init_readys_low", bad_rdy, 0);
    chk("init_done_low", bad_done, 0);
    if (n == 512) begin
      rd0_valid = 1'b0; rd1_valid = 1'b0; wr_valid = 1'b0;
      @(negedge clock);
      chk("init_done_rise", init_done, 1);
      chk("run_w_en_idle", sram_w_en, 0);
      @(posedge clock); #1;
      for (int i = 0; i < 512; i++) exp_mem[i] = 11'h000;
    end
  endtask

  task automatic run_cycle(input logic v0, input logic [8:0] a0, input logic v1,
                           input logic [8:0] a1, input logic wv, input logic [8:0] wa,
                           input logic [10:0] wd);
    logic e_r0, e_r1, g0, g1;
    logic [8:0]  ra;
    logic [11:0] e;
    rd0_valid = v0; rd0_addr = a0; rd1_valid = v1; rd1_addr = a1;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
    @(negedge clock);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("resp_valid", resp_valid, 1);
      chk("resp_id", resp_id, e[11]);
      chk("resp_data", resp_data, e[10:0]);
    end else begin
      chk("resp_idle", resp_valid, 0);
    end
    if (RR) begin
      e_r0 = !pref || !v1;
      e_r1 = pref || !v0;
    end else begin
      e_r0 = 1'b1;
      e_r1 = !v0;
    end
    g0 = v0 && e_r0;
    g1 = v1 && e_r1;
    chk("rd0_ready", rd0_ready, e_r0);
    chk("rd1_ready", rd1_ready, e_r1);
    chk("wr_ready", wr_ready, 1);
    chk("sram_r_en", sram_r_en, g0 || g1);
    chk("sram_w_en", sram_w_en, wv);
    if (g0 || g1) begin
      ra = g1 ? a1 : a0;
      exp_q.push_back({g1, (wv && wa == ra) ? wd : exp_mem[ra]});
      pref = g0 ? 1'b1 : 1'b0;
    end
    if (wv) exp_mem[wa] = wd;
    @(posedge clock); #1;
  endtask

  task automatic random_traffic(input int n);
    for (int i = 0; i < n; i++)
      run_cycle(1'($urandom), 9'($urandom_range(0, 15)), 1'($urandom),
                9'($urandom_range(0, 15)), 1'($urandom), 9'($urandom_range(0, 15)),
                11'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) sram[i] = 11'($urandom);
    @(posedge clock); #1;
    apply_reset();
    init_sweep(200);
    apply_reset();
    init_sweep(512);

    run_cycle(0, 0, 0, 0, 1, 9'h1A3, 11'h5A5);
    run_cycle(0, 0, 1, 9'h1A3, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0);

    run_cycle(0, 0, 0, 0, 1, 9'd3, 11'h123);
    run_cycle(0, 0, 0, 0, 1, 9'd7, 11'h456);
    for (int i = 0; i < 4; i++) run_cycle(1, 9'd3, 1, 9'd7, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0);

    run_cycle(1, 9'h010, 0, 0, 1, 9'h010, 11'h7FF);
    run_cycle(0, 0, 0, 0, 0, 0, 0);

    run_cycle(1, 9'h0FF, 0, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0, 0, 0);

    random_traffic(400);

    run_cycle(1, 9'h1A3, 0, 0, 0, 0, 0);
    chk("pending_resp", resp_valid, 1);
    apply_reset();
    init_sweep(512);
    run_cycle(1, 9'h1A3, 1, 9'h010, 0, 0, 0);
    random_traffic(100);
    run_cycle(0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
